// File: rtl/bcd_updown_count_if.sv
// Signal bundle between a BCD up/down counter and whatever drives it.
// Master drives the controls and load value; slave is the counter itself.
interface bcd_updown_count_if #(
  parameter int unsigned DIGITS = 2
) ();
  logic                  CE;
  logic                  UD;
  logic                  LD;
  logic [4*DIGITS-1:0]   D;
  logic [4*DIGITS-1:0]   Q;
  logic                  CO;
  logic                  ERR;

  modport master (
    output CE, UD, LD, D,
    input  Q, CO, ERR
  );

  modport slave (
    input  CE, UD, LD, D,
    output Q, CO, ERR
  );
endinterface

// File: rtl/bcd_updown_count.sv
// Synchronous N-digit BCD up/down counter with parallel load and cascade output.
// Digit carries and borrows are combinational enables; every digit runs on CK.
module bcd_updown_count #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                     CK,
  input  logic                     SR,
  bcd_updown_count_if.slave        bus
);
  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0]      q_q, q_d;
  logic              err_q, err_d;
  logic [DIGITS-1:0] step_up, step_dn;
  logic              all9, all0;

  // step_up[i] is high when every lower digit is 9 (ripple enable, not a clock)
  always_comb begin
    logic run_up, run_dn;
    run_up = 1'b1;
    run_dn = 1'b1;
    step_up = '0;
    step_dn = '0;
    for (int i = 0; i < DIGITS; i++) begin
      step_up[i] = run_up;
      step_dn[i] = run_dn;
      run_up     = run_up & (q_q[4*i +: 4] == 4'd9);
      run_dn     = run_dn & (q_q[4*i +: 4] == 4'd0);
    end
    all9 = run_up;
    all0 = run_dn;
  end

  always_comb begin
    logic [3:0] dig;
    q_d   = q_q;
    err_d = err_q;
    dig   = 4'd0;
    if (bus.LD) begin
      for (int i = 0; i < DIGITS; i++) begin
        dig = bus.D[4*i +: 4];
        if (dig > 4'd9) begin
          q_d[4*i +: 4] = 4'd0;
          err_d         = 1'b1;
        end else begin
          q_d[4*i +: 4] = dig;
        end
      end
    end else if (bus.CE) begin
      for (int i = 0; i < DIGITS; i++) begin
        dig = q_q[4*i +: 4];
        if (bus.UD && step_up[i]) begin
          q_d[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        end else if (!bus.UD && step_dn[i]) begin
          q_d[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CK) begin
    if (SR) begin
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign bus.Q   = q_q;
  assign bus.ERR = err_q;
  // High only on the edge that wraps, so it can drive the next stage's CE directly
  assign bus.CO  = bus.CE & ~bus.LD & ~SR & (bus.UD ? all9 : all0);

endmodule

// File: doc/bcd_updown_count.md
# bcd_updown_count

Parametrised synchronous N-digit BCD up/down counter with parallel load, replacing the ripple-clocked one- and two-digit BCD counters. All digits run on the single clock CK; digit-to-digit carry and borrow are combinational enables, never derived clocks. It is the timing and event-count core for display and stopwatch datapaths, and cascades through CO for counts wider than DIGITS.

## Interface
Parameters:
- DIGITS, 2, number of BCD digits (1..8); Q width = 4*DIGITS.

Ports:
- CK  in  1  clock; all state changes on the rising edge.
- SR  in  1  reset; one clock; reset is synchronous and active-high.
- CE  in  1  count enable; one step per CK edge while high.
- UD  in  1  direction: 1 = up, 0 = down; sampled with CE.
- LD  in  1  parallel load strobe.
- D   in  4*DIGITS  load value, digit i in D[4i+3:4i], digit 0 least significant.
- Q   out 4*DIGITS  current count, same digit layout as D.
- CO  out 1  terminal-count / cascade output, combinational.
- ERR out 1  sticky flag: a non-BCD digit was presented on load.

## Operation
- Priority on each rising CK edge: SR > LD > CE. Inputs not covered by that priority are ignored that cycle.
- SR=1: Q <= 0, ERR <= 0.
- LD=1 (SR=0): each digit i loads D digit i if it is ≤9. A digit >9 loads 0 and sets ERR <= 1. ERR is cleared only by SR. LD ignores CE and UD.
- CE=1, UD=1 (up): digit 0 increments. Digit i>0 increments only when all lower digits are 9. A digit at 9 that steps wraps to 0. The all-9s state goes to all-0s.
- CE=1, UD=0 (down): digit 0 decrements. Digit i>0 decrements only when all lower digits are 0. A digit at 0 that steps wraps to 9. The all-0s state goes to all-9s.
- CE=0, LD=0, SR=0: Q holds.
- CO = CE & ~LD & ~SR & ((UD & Q==all-9s) | (~UD & Q==all-0s)). CO is high exactly in the cycle whose edge causes wrap-around, so CO feeds the next counter's CE directly.
- Q digits are never >9 in any state reachable after SR or LD.
- Q is undefined before the first SR; the bench must apply SR first.

## Timing
- Reset values after an SR edge: Q=0, ERR=0. CO after reset = CE & ~UD & ~LD, because Q=0 is the down-terminal state.
- Latency: one CK edge from CE/LD/SR to the updated Q. Q is registered with no combinational path from inputs to Q.
- CO path: combinational from CE, UD, LD, SR and registered Q; no extra register stage.
- Direction change takes effect on the same edge where UD is sampled. Toggling UD mid-count gives no glitch steps and no skipped values.
- LD and CE high together: load wins and CO=0.
- SR and LD high together: reset wins, and ERR is not set even if D holds bad digits.
- SR in the middle of a count or carry chain: every digit clears on that edge, with no partial carry.
- Cascading two instances, with CO of the low instance driving CE of the high one and shared UD: the result behaves as one 2*DIGITS counter, with the same edge timing.

## Test plan
- DIGITS=2: SR, then CE=1, UD=1 for 100 edges. Q steps 00..99 in BCD (never 0x0A..0x0F). CO is high only in the cycle Q=99. The edge after that gives Q=00.
- DIGITS=2: SR, then CE=1, UD=0. The first edge gives Q=99. CO is high in the reset-following cycle (Q=00). Then 98, 97, …, with 90→89 crossing correctly.
- LD with D=0x47 while CE=1, UD=1: the next edge gives Q=47 and CO=0. The following edge gives 48. Then UD=0 for 8 edges gives 40, then 39.
- LD with D=0x3C: Q=30, ERR=1. ERR stays 1 through counting and a later valid load. SR clears it to 0.
- SR asserted with LD=1 and CE=1 at Q=59: Q=00, ERR=0. CE=0 for 5 edges: Q holds 00.
- Two DIGITS=2 instances cascaded via CO→CE, counting up from 9998 (loaded): the sequence is 9999, 0000, with the high CO pulsing for exactly one cycle at 9999.
